// File: rtl/touch_painter_if.sv
// rtl/touch_painter_if.sv - framebuffer write port with valid/ready handshake
interface touch_painter_if #(
  parameter int ADDR_BITS  = 17,
  parameter int COLOR_BITS = 16
);
  logic                  wr_valid;
  logic [ADDR_BITS-1:0]  wr_addr;
  logic [COLOR_BITS-1:0] wr_data;
  logic                  wr_ready;

  modport master (output wr_valid, wr_addr, wr_data, input wr_ready);
  modport slave  (input wr_valid, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/touch_painter.sv
// rtl/touch_painter.sv - paints a clipped square brush per new touch point, or clears the screen
module touch_painter #(
  parameter int DISPLAY_WIDTH  = 240,
  parameter int DISPLAY_HEIGHT = 320,
  parameter int BRUSH_SIZE     = 3,
  parameter int COLOR_BITS     = 16,
  parameter int ADDR_BITS      = $clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [30:0]           touch,
  input  logic [COLOR_BITS-1:0] fg_color,
  input  logic [COLOR_BITS-1:0] bg_color,
  input  logic                  clear,
  touch_painter_if.master       wr,
  output logic                  busy
);
  localparam logic signed [13:0]    H_S    = 14'(BRUSH_SIZE/2);
  localparam logic signed [13:0]    XMAX_S = 14'(DISPLAY_WIDTH-1);
  localparam logic signed [13:0]    YMAX_S = 14'(DISPLAY_HEIGHT-1);
  localparam logic [ADDR_BITS-1:0]  W_A    = ADDR_BITS'(DISPLAY_WIDTH);
  localparam logic [ADDR_BITS-1:0]  LAST_A = ADDR_BITS'(DISPLAY_WIDTH*DISPLAY_HEIGHT-1);

  typedef enum logic [1:0] {S_IDLE, S_PAINT, S_CLEAR} state_t;

  state_t               r_state;
  logic                 r_clear_pending;
  logic                 r_last_valid;
  logic [11:0]          r_last_x, r_last_y;
  logic [11:0]          r_bx, r_by, r_x0, r_x1, r_y1;
  logic [ADDR_BITS-1:0] r_row_base;

  // touch word layout: {valid, x[11:0], y[11:0], contact[1:0], id[3:0]}
  logic        w_valid;
  logic [11:0] w_tx, w_ty;
  logic [1:0]  w_contact;
  logic        w_unused;
  assign w_valid   = touch[30];
  assign w_tx      = touch[29:18];
  assign w_ty      = touch[17:6];
  assign w_contact = touch[5:4];
  assign w_unused  = &{1'b0, touch[3:0]};

  logic w_idle, w_clear_start, w_accept, w_dedupe_drop, w_same, w_in_range, w_contact_ok;
  assign w_idle        = (r_state == S_IDLE);
  assign w_clear_start = w_idle && (clear || r_clear_pending);
  assign w_contact_ok  = (w_contact == 2'b00) || (w_contact == 2'b10);
  assign w_in_range    = (w_tx < 12'(DISPLAY_WIDTH)) && (w_ty < 12'(DISPLAY_HEIGHT));
  assign w_same        = r_last_valid && (w_tx == r_last_x) && (w_ty == r_last_y);
  assign w_accept      = w_idle && !w_clear_start && w_valid && w_contact_ok && w_in_range && !w_same;
  assign w_dedupe_drop = !w_valid || (w_contact == 2'b01) || w_clear_start;

  // Signed 14-bit extents so x-H below zero clamps instead of wrapping.
  logic signed [13:0] w_xs, w_ys, w_xlo, w_xhi, w_ylo, w_yhi;
  logic [11:0]        w_x0, w_x1, w_y0, w_y1;
  assign w_xs  = $signed({2'b00, w_tx});
  assign w_ys  = $signed({2'b00, w_ty});
  assign w_xlo = w_xs - H_S;
  assign w_xhi = w_xs + H_S;
  assign w_ylo = w_ys - H_S;
  assign w_yhi = w_ys + H_S;
  assign w_x0  = (w_xlo < 14'sd0)   ? 12'd0 : w_xlo[11:0];
  assign w_x1  = (w_xhi > XMAX_S)   ? 12'(DISPLAY_WIDTH-1) : w_xhi[11:0];
  assign w_y0  = (w_ylo < 14'sd0)   ? 12'd0 : w_ylo[11:0];
  assign w_y1  = (w_yhi > YMAX_S)   ? 12'(DISPLAY_HEIGHT-1) : w_yhi[11:0];

  logic [ADDR_BITS-1:0] w_start_row;
  assign w_start_row = ADDR_BITS'(w_y0) * W_A;

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state         <= S_IDLE;
      r_clear_pending <= 1'b0;
      r_last_valid    <= 1'b0;
      r_last_x        <= '0;
      r_last_y        <= '0;
      r_bx            <= '0;
      r_by            <= '0;
      r_x0            <= '0;
      r_x1            <= '0;
      r_y1            <= '0;
      r_row_base      <= '0;
      wr.wr_valid     <= 1'b0;
      wr.wr_addr      <= '0;
      wr.wr_data      <= '0;
    end else begin
      if (w_dedupe_drop) begin
        r_last_valid <= 1'b0;
      end else if (w_accept) begin
        r_last_valid <= 1'b1;
        r_last_x     <= w_tx;
        r_last_y     <= w_ty;
      end
      case (r_state)
        S_IDLE: begin
          if (w_clear_start) begin
            r_state         <= S_CLEAR;
            r_clear_pending <= 1'b0;
            wr.wr_valid     <= 1'b1;
            wr.wr_addr      <= '0;
            wr.wr_data      <= bg_color;
          end else if (w_accept) begin
            r_state     <= S_PAINT;
            r_bx        <= w_x0;
            r_by        <= w_y0;
            r_x0        <= w_x0;
            r_x1        <= w_x1;
            r_y1        <= w_y1;
            r_row_base  <= w_start_row;
            wr.wr_valid <= 1'b1;
            wr.wr_addr  <= w_start_row + ADDR_BITS'(w_x0);
            wr.wr_data  <= fg_color;
          end
        end
        S_PAINT: begin
          if (clear) r_clear_pending <= 1'b1;
          if (wr.wr_ready) begin
            if (r_bx != r_x1) begin
              r_bx       <= r_bx + 12'd1;
              wr.wr_addr <= wr.wr_addr + 1'b1;
            end else if (r_by != r_y1) begin
              r_bx       <= r_x0;
              r_by       <= r_by + 12'd1;
              r_row_base <= r_row_base + W_A;
              wr.wr_addr <= r_row_base + W_A + ADDR_BITS'(r_x0);
            end else begin
              r_state     <= S_IDLE;
              wr.wr_valid <= 1'b0;
            end
          end
        end
        S_CLEAR: begin
          if (wr.wr_ready) begin
            if (wr.wr_addr == LAST_A) begin
              r_state     <= S_IDLE;
              wr.wr_valid <= 1'b0;
            end else begin
              wr.wr_addr <= wr.wr_addr + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_touch_painter.sv
// tb/tb_touch_painter.sv - table, hand-written and random checks of touch_painter
module tb_touch_painter;
  localparam int W = 240;
  localparam int H = 320;
  localparam int HB = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [30:0] touch = '0;
  logic [15:0] fg_color = '0;
  logic [15:0] bg_color = '0;
  logic        clear = 1'b0;
  logic        busy;
  logic        rand_mode = 1'b0;

  touch_painter_if #(.ADDR_BITS(17), .COLOR_BITS(16)) wr_if();

  touch_painter dut (
    .clk(clk), .rst(rst), .touch(touch), .fg_color(fg_color), .bg_color(bg_color),
    .clear(clear), .wr(wr_if), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cap_addr[$];
  int cap_data[$];
  int exp_q[$];

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    wr_if.wr_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  logic        prev_stall = 1'b0;
  logic [16:0] prev_addr = '0;
  logic [15:0] prev_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      if (prev_stall) begin
        check("hold_valid", int'(wr_if.wr_valid), 1);
        check("hold_addr", int'(wr_if.wr_addr), int'(prev_addr));
        check("hold_data", int'(wr_if.wr_data), int'(prev_data));
      end
      if (wr_if.wr_valid && wr_if.wr_ready) begin
        cap_addr.push_back(int'(wr_if.wr_addr));
        cap_data.push_back(int'(wr_if.wr_data));
      end
      prev_stall = wr_if.wr_valid && !wr_if.wr_ready;
      prev_addr  = wr_if.wr_addr;
      prev_data  = wr_if.wr_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Reference: the clipped square around (x,y), listed row by row.
  function automatic void model_touch(input int x, input int y, input logic [1:0] c, input logic v);
    exp_q.delete();
    if (!v || !(c == 2'b00 || c == 2'b10) || x >= W || y >= H) return;
    for (int yy = y - HB; yy <= y + HB; yy++)
      for (int xx = x - HB; xx <= x + HB; xx++)
        if (xx >= 0 && xx < W && yy >= 0 && yy < H) exp_q.push_back(yy * W + xx);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_touch(input int x, input int y, input logic [1:0] c, input logic v);
    touch = {v, 12'(x), 12'(y), c, 4'h5};
  endtask

  task automatic drop_touch();
    touch = {1'b0, 12'd0, 12'd0, 2'b01, 4'h0};
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget && busy; i++) tick();
    check({name, "_idle"}, int'(busy), 0);
  endtask

  task automatic compare_brush(input string name, input int col);
    int bad = 0;
    check({name, "_count"}, cap_addr.size(), exp_q.size());
    for (int i = 0; i < cap_addr.size() && i < exp_q.size(); i++)
      if (cap_addr[i] != exp_q[i] || cap_data[i] != col) bad++;
    check({name, "_seq"}, bad, 0);
  endtask

  task automatic run_touch(input int x, input int y, input logic [1:0] c, input logic v,
                           input logic [15:0] col, input string name);
    drop_touch();
    tick();
    cap_addr.delete();
    cap_data.delete();
    fg_color = col;
    drive_touch(x, y, c, v);
    tick();
    drop_touch();
    wait_idle(name, 200);
    tick();
    tick();
    model_touch(x, y, c, v);
    compare_brush(name, int'(col));
  endtask

  typedef struct {
    int         x;
    int         y;
    logic [1:0] c;
    logic       v;
    int         n;
    int         first;
    int         last;
    string      name;
  } vec_t;
  vec_t vecs[10];

  initial begin
    int n, bad, fg_hits;
    vecs[0] = '{100, 50, 2'b00, 1'b1, 9, 11859, 12341, "centre"};
    vecs[1] = '{0, 0, 2'b00, 1'b1, 4, 0, 241, "corner_tl"};
    vecs[2] = '{239, 319, 2'b10, 1'b1, 4, 76558, 76799, "corner_br"};
    vecs[3] = '{239, 0, 2'b00, 1'b1, 4, 238, 479, "corner_tr"};
    vecs[4] = '{240, 10, 2'b00, 1'b1, 0, 0, 0, "x_oob"};
    vecs[5] = '{10, 320, 2'b00, 1'b1, 0, 0, 0, "y_oob"};
    vecs[6] = '{100, 50, 2'b01, 1'b1, 0, 0, 0, "lift"};
    vecs[7] = '{100, 50, 2'b11, 1'b1, 0, 0, 0, "contact_11"};
    vecs[8] = '{100, 50, 2'b00, 1'b0, 0, 0, 0, "not_valid"};
    vecs[9] = '{5, 7, 2'b10, 1'b1, 9, 1444, 1926, "contact_10"};

    drop_touch();
    repeat (3) tick();
    check("rst_wr_valid", int'(wr_if.wr_valid), 0);
    check("rst_wr_addr", int'(wr_if.wr_addr), 0);
    check("rst_wr_data", int'(wr_if.wr_data), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b1;
    tick();

    foreach (vecs[i]) begin
      run_touch(vecs[i].x, vecs[i].y, vecs[i].c, vecs[i].v, 16'(16'hA000 + i), vecs[i].name);
      check({vecs[i].name, "_n"}, cap_addr.size(), vecs[i].n);
      if (vecs[i].n > 0 && cap_addr.size() > 0) begin
        check({vecs[i].name, "_first"}, cap_addr[0], vecs[i].first);
        check({vecs[i].name, "_last"}, cap_addr[cap_addr.size()-1], vecs[i].last);
      end
    end

    // Latency and throughput with wr_ready held high.
    drop_touch();
    tick();
    fg_color = 16'h1357;
    drive_touch(120, 200, 2'b00, 1'b1);
    tick();
    drop_touch();
    check("lat_valid", int'(wr_if.wr_valid), 1);
    check("lat_addr", int'(wr_if.wr_addr), 199 * W + 119);
    check("lat_data", int'(wr_if.wr_data), 16'h1357);
    check("lat_busy", int'(busy), 1);
    n = 0;
    while (wr_if.wr_valid && n < 20) begin
      n++;
      tick();
    end
    check("tput_cycles", n, 9);
    check("tput_busy_after", int'(busy), 0);

    // Held touch paints once; a one-cycle gap re-arms the same point.
    drop_touch();
    tick();
    cap_addr.delete();
    cap_data.delete();
    drive_touch(100, 50, 2'b00, 1'b1);
    repeat (50) tick();
    check("dedupe_hold", cap_addr.size(), 9);
    drop_touch();
    tick();
    drive_touch(100, 50, 2'b00, 1'b1);
    repeat (20) tick();
    drop_touch();
    wait_idle("dedupe_rearm", 50);
    check("dedupe_rearm", cap_addr.size(), 18);

    // Clear requested mid-brush: brush finishes, then full clear.
    drop_touch();
    tick();
    cap_addr.delete();
    cap_data.delete();
    fg_color = 16'hABCD;
    bg_color = 16'h1234;
    drive_touch(100, 50, 2'b00, 1'b1);
    tick();
    drop_touch();
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    wait_idle("mid_brush", 50);
    tick();
    check("clear_started", int'(busy), 1);
    wait_idle("clear_full", 80000);
    tick();
    check("clear_total", cap_addr.size(), 9 + W * H);
    model_touch(100, 50, 2'b00, 1'b1);
    bad = 0;
    for (int i = 0; i < cap_addr.size(); i++) begin
      if (i < 9) begin
        if (cap_addr[i] != exp_q[i] || cap_data[i] != 16'hABCD) bad++;
      end else if (cap_addr[i] != i - 9 || cap_data[i] != 16'h1234) begin
        bad++;
      end
    end
    check("clear_seq", bad, 0);

    // Clear and touch together: clear wins; then reset mid-sweep.
    drop_touch();
    tick();
    cap_addr.delete();
    cap_data.delete();
    fg_color = 16'h0F0F;
    bg_color = 16'h7777;
    drive_touch(50, 60, 2'b00, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    drop_touch();
    check("ct_valid", int'(wr_if.wr_valid), 1);
    check("ct_addr", int'(wr_if.wr_addr), 0);
    check("ct_data", int'(wr_if.wr_data), 16'h7777);
    n = 0;
    while (wr_if.wr_addr < 1000 && n < 2000) begin
      n++;
      tick();
    end
    check("reach_1000", int'(wr_if.wr_addr >= 1000), 1);
    fg_hits = 0;
    foreach (cap_data[i]) if (cap_data[i] == 16'h0F0F) fg_hits++;
    check("ct_touch_dropped", fg_hits, 0);
    rst = 1'b0;
    tick();
    check("mid_rst_valid", int'(wr_if.wr_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_addr", int'(wr_if.wr_addr), 0);
    rst = 1'b1;
    tick();
    run_touch(0, 0, 2'b00, 1'b1, 16'h2468, "post_rst");

    // Backpressure on a known brush, then random touches.
    rand_mode = 1'b1;
    run_touch(100, 50, 2'b00, 1'b1, 16'h5A5A, "bp_centre");
    for (int k = 0; k < 25; k++) begin
      int rx, ry, rc;
      rx = $urandom_range(0, 249);
      ry = $urandom_range(0, 329);
      rc = $urandom_range(0, 3);
      if (k % 3 == 0) rx = (k % 2 == 0) ? 0 : 239;
      run_touch(rx, ry, 2'(rc), 1'b1, 16'($urandom), $sformatf("rand%0d", k));
    end
    rand_mode = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/touch_painter.md
# touch_painter

Downstream consumer of the FT6206 touch controller's `touch0` output in the etch-a-sketch datapath. It converts each new valid touch point into a square brush of pixel writes on a framebuffer (VRAM) write port, clipped to the display. It also performs a full-screen clear sweep on request. The write port uses a valid/ready handshake so the block can sit in front of a display or VRAM arbiter.

## Interface
- `DISPLAY_WIDTH`, 240: pixels per row.
- `DISPLAY_HEIGHT`, 320: rows.
- `BRUSH_SIZE`, 3: brush edge length in pixels; must be odd, 1..15.
- `COLOR_BITS`, 16: pixel data width.
- `ADDR_BITS`, $clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT) (17): VRAM address width.

Ports:
- `clk` input, 1: the single clock.
- `rst` input, 1: synchronous, active-low reset (reset when `rst`==0 at a `clk` edge).
- `touch` input, touch_t: touch point `{valid, x[11:0], y[11:0], contact[1:0], id[3:0]}` from the touch controller.
- `fg_color` input, COLOR_BITS: brush colour, sampled when a touch is accepted.
- `bg_color` input, COLOR_BITS: clear colour, sampled when a clear starts.
- `clear` input, 1: one-cycle or level request for a full-screen clear.
- `wr_valid` output, 1: write request.
- `wr_addr` output, ADDR_BITS: pixel address, equal to y*DISPLAY_WIDTH + x.
- `wr_data` output, COLOR_BITS: pixel colour.
- `wr_ready` input, 1: sink accepts the write on a cycle where `wr_valid & wr_ready`.
- `busy` output, 1: high whenever the block is not in S_IDLE.

## Operation
- FSM states: S_IDLE, S_PAINT, S_CLEAR.
- **Touch acceptance**, S_IDLE only. A touch is accepted when:
  - `touch.valid`==1,
  - `contact` is 2'b00 (press) or 2'b10 (contact),
  - `x < DISPLAY_WIDTH` and `y < DISPLAY_HEIGHT`,
  - and (x,y) differs from the last painted point, or no last point is held.
- On acceptance: latch x, y and `fg_color`, record (x,y) as the last point, and go to S_PAINT.
- **Dedupe reset:** the last-point record is invalidated when `touch.valid`==0, when `contact`==2'b01 (lift), or when a clear starts.
- **Brush extent:** H = BRUSH_SIZE/2.
  - x0 = max(x−H, 0), x1 = min(x+H, DISPLAY_WIDTH−1); y0 and y1 are computed likewise.
  - Compute with at least 13-bit signed intermediates; no wrap-around is allowed.
- **S_PAINT:** walk (bx,by) row-major with bx as the inner loop, from (x0,y0) to (x1,y1).
  - Present `wr_addr` = by*DISPLAY_WIDTH + bx and `wr_data` = latched colour.
  - On the last handshake, at (x1,y1), go to S_IDLE.
- **S_CLEAR:** `wr_addr` counts 0 .. DISPLAY_WIDTH*DISPLAY_HEIGHT−1 with `wr_data` = latched `bg_color`. After the last handshake, go to S_IDLE.
- **Priority in S_IDLE:** a pending clear beats a touch in the same cycle. That touch is dropped, not queued.
- **Clear during S_PAINT:** the request is latched into `clear_pending` and serviced from S_IDLE after the brush completes.
- **Clear during S_CLEAR:** ignored, and `clear_pending` is not set.
- **Touches during S_PAINT or S_CLEAR:** ignored and not queued. The dedupe invalidation rules still apply.
- Address arithmetic uses only multiplication by a constant; an incrementing row base (+DISPLAY_WIDTH per row) is acceptable.

## Timing
- **Reset values:** `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, state S_IDLE, `clear_pending`=0, last point invalid.
- **Reset mid-operation:** the sweep is aborted immediately and the block is back in the reset state on the next cycle.
- **Latency:** a touch accepted at edge N gives `wr_valid`=1 with the first address after edge N (registered outputs). Clear has the same latency.
- **Handshake:**
  - While `wr_valid`=1, `wr_addr` and `wr_data` hold stable until `wr_valid & wr_ready`.
  - The next pixel is presented on the following cycle with no bubble, so throughput is 1 pixel/cycle when `wr_ready`=1.
  - `wr_valid` never drops before the sweep completes.
  - `wr_valid` may be asserted independently of `wr_ready`.
- `wr_valid` deasserts in the cycle after the final handshake. `busy` is low on that same cycle.
- Minimum time S_IDLE→S_IDLE for a full 3×3 brush with `wr_ready` held high: 9 cycles of `wr_valid` plus 1 idle cycle before the next acceptance.
- A full clear takes DISPLAY_WIDTH*DISPLAY_HEIGHT handshakes (76800 at defaults).

## Test plan
- **Centre touch:** touch (100,50), contact 2'b00, `wr_ready`=1 → exactly 9 writes, addresses 11859, 11860, 11861, 12099, 12100, 12101, 12339, 12340, 12341, all with `fg_color`; then `busy`=0.
- **Corner clip:** touch (0,0) → 4 writes at 0, 1, 240, 241. Touch (239,319) → 4 writes at 76558, 76559, 76798, 76799.
- **Backpressure:** toggle `wr_ready` pseudo-randomly during a brush → `wr_addr`/`wr_data` stable while stalled, same 9-address sequence, no drops or duplicates.
- **Dedupe and reject:**
  - Hold touch (100,50) valid for 50 cycles → only one brush.
  - Deassert `valid` for 1 cycle, then reassert the same point → a second brush.
  - Touch x=240 or contact 2'b01 → no writes.
- **Clear interactions:**
  - Assert `clear` mid-brush → the brush completes, then 76800 writes of `bg_color` at 0..76799.
  - `clear` together with a touch in S_IDLE → clear only.
- **Reset mid-sweep:** drive `rst`=0 during a clear at address ~1000 → next cycle `wr_valid`=0, `busy`=0. After release, a touch produces a normal brush.
